// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared opcodes, field positions and state encoding for the SPU sequencer
package spu_pkg;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_BEQ  = 4'h3;
  localparam logic [3:0] OP_BNE  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int BR_OFS_W = 6;
  localparam int JMP_W    = 12;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic opcode_legal(input logic [3:0] op);
    return (op <= OP_JMP) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/spu_control_fsm_if.sv
// rtl/spu_control_fsm_if.sv - sequencer-to-datapath/memory signal bundle
interface spu_control_fsm_if;
  logic        run;
  logic [15:0] instruction;
  logic        alu_zero;
  logic        mem_ready;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        reg_write_enable;
  logic        mem_req;
  logic        mem_read;
  logic        mem_write_enable;
  logic        halted;
  logic        illegal;
  logic [15:0] instr_count;

  modport master (
    input  run, instruction, alu_zero, mem_ready,
    output pc, ir, reg_write_enable, mem_req, mem_read, mem_write_enable,
           halted, illegal, instr_count
  );

  modport slave (
    output run, instruction, alu_zero, mem_ready,
    input  pc, ir, reg_write_enable, mem_req, mem_read, mem_write_enable,
           halted, illegal, instr_count
  );
endinterface

// File: rtl/spu_next_pc.sv
// rtl/spu_next_pc.sv - next-PC selection: sequential, branch target or jump target
module spu_next_pc
  import spu_pkg::*;
#(
  parameter logic [15:0] PC_STEP = 16'd2
) (
  input  logic [15:0] pc_i,
  input  logic [15:0] ir_i,
  input  logic        alu_zero_i,
  input  state_t      state_i,
  output logic [15:0] pc_next_o
);

  logic [3:0]  op;
  logic [15:0] pc_seq;
  logic [15:0] br_ofs;
  logic [15:0] jmp_tgt;
  logic        taken;

  assign op      = opcode_of(ir_i);
  assign pc_seq  = pc_i + PC_STEP;
  // Word offset scaled to bytes; range -64..+62 relative to pc+2.
  assign br_ofs  = {{(16-BR_OFS_W-1){ir_i[BR_OFS_W-1]}}, ir_i[BR_OFS_W-1:0], 1'b0};
  assign jmp_tgt = {pc_i[15:JMP_W+1], ir_i[JMP_W-1:0], 1'b0};
  assign taken   = ((op == OP_BEQ) && alu_zero_i) || ((op == OP_BNE) && !alu_zero_i);

  always_comb begin
    pc_next_o = pc_seq;
    if (state_i == EXEC) begin
      if (op == OP_JMP)
        pc_next_o = jmp_tgt;
      else if (taken)
        pc_next_o = pc_seq + br_ofs;
    end
  end

endmodule

// File: rtl/spu_control_fsm.sv
// rtl/spu_control_fsm.sv - multi-cycle fetch/decode/exec/mem/writeback sequencer owning the PC
module spu_control_fsm
  import spu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic               clk,
  input  logic               rst_n,
  spu_control_fsm_if.master  bus
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] cnt_q, cnt_d;
  logic        illegal_q, illegal_d;
  logic [15:0] pc_next;
  logic [3:0]  op;
  logic        retire;

  assign op = opcode_of(ir_q);

  spu_next_pc #(.PC_STEP(PC_STEP)) u_next_pc (
    .pc_i       (pc_q),
    .ir_i       (ir_q),
    .alu_zero_i (bus.alu_zero),
    .state_i    (state_q),
    .pc_next_o  (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      cnt_q     <= 16'h0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    illegal_d = illegal_q;
    ir_d      = ir_q;
    unique case (state_q)
      IDLE:   if (bus.run) state_d = FETCH;
      FETCH: begin
        ir_d    = bus.instruction;
        state_d = DECODE;
      end
      DECODE: begin
        if (op == OP_HALT) begin
          state_d = HALT;
        end else if (!opcode_legal(op)) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op == OP_ALU)                        state_d = WB;
        else if ((op == OP_LD) || (op == OP_ST)) state_d = MEM;
        else                                     retire  = 1'b1;
      end
      MEM: begin
        if (bus.mem_ready) begin
          if (op == OP_LD) state_d = WB;
          else             retire  = 1'b1;
        end
      end
      WB:     retire = 1'b1;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
    // run is only consulted at the boundary so a drop never aborts an instruction.
    if (retire)
      state_d = bus.run ? FETCH : IDLE;
    pc_d  = retire ? pc_next : pc_q;
    cnt_d = cnt_q + {15'd0, retire};
  end

  always_comb begin
    bus.mem_req          = 1'b0;
    bus.mem_read         = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.reg_write_enable = 1'b0;
    bus.halted           = 1'b0;
    case (state_q)
      MEM: begin
        bus.mem_req          = 1'b1;
        bus.mem_read         = (op == OP_LD);
        bus.mem_write_enable = (op == OP_ST);
      end
      WB:      bus.reg_write_enable = 1'b1;
      HALT:    bus.halted           = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.instr_count = cnt_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_spu_control_fsm.sv
// tb/tb_spu_control_fsm.sv - directed self-checking bench for the SPU sequencer
module tb_spu_control_fsm;

  logic clk;
  logic rst_n;
  logic [15:0] rom [16];
  int checks;
  int errors;
  int n_we, n_req, n_rd, n_wr, n_multi;

  spu_control_fsm_if bus ();

  spu_control_fsm #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.instruction = rom[bus.pc[4:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_we = 0; n_req = 0; n_rd = 0; n_wr = 0; n_multi = 0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_we  += int'(bus.reg_write_enable);
      n_req += int'(bus.mem_req);
      n_rd  += int'(bus.mem_read);
      n_wr  += int'(bus.mem_write_enable);
      if ((int'(bus.reg_write_enable) + int'(bus.mem_read) + int'(bus.mem_write_enable)) > 1)
        n_multi++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.mem_ready = 1'b1;
    bus.alu_zero = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 16'hF000;
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    bus.run = 1'b0;
    bus.mem_ready = 1'b1;
    bus.alu_zero = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 16'hF000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_ir", bus.ir, 16'h0000);
    chk("rst_cnt", bus.instr_count, 16'h0000);
    chk("rst_strobes", {12'd0, bus.reg_write_enable, bus.mem_req, bus.mem_read, bus.mem_write_enable}, 16'h0);
    chk("rst_flags", {14'd0, bus.halted, bus.illegal}, 16'h0);

    // ALU: writeback strobe in the fourth cycle after run
    do_reset();
    rom[0] = 16'h2123;
    bus.run = 1'b1;
    step(3);
    chk("alu_we_early", 16'(n_we), 16'd0);
    step(1);
    chk("alu_we_c4", {15'd0, bus.reg_write_enable}, 16'd1);
    step(1);
    chk("alu_we_after", {15'd0, bus.reg_write_enable}, 16'd0);
    chk("alu_pc", bus.pc, 16'h0002);
    chk("alu_cnt", bus.instr_count, 16'd1);
    chk("alu_ir", bus.ir, 16'h2123);
    step(2);
    chk("halt_flag", {15'd0, bus.halted}, 16'd1);
    chk("halt_not_illegal", {15'd0, bus.illegal}, 16'd0);
    chk("halt_pc", bus.pc, 16'h0002);
    chk("halt_cnt", bus.instr_count, 16'd1);

    // LD with three wait cycles
    do_reset();
    rom[0] = 16'h0000;
    bus.mem_ready = 1'b0;
    bus.run = 1'b1;
    step(7);
    bus.mem_ready = 1'b1;
    step(2);
    chk("ld_req_cycles", 16'(n_req), 16'd4);
    chk("ld_rd_cycles", 16'(n_rd), 16'd4);
    chk("ld_wr_cycles", 16'(n_wr), 16'd0);
    chk("ld_we_pulses", 16'(n_we), 16'd1);
    chk("ld_pc", bus.pc, 16'h0002);
    chk("ld_cnt", bus.instr_count, 16'd1);

    // ST with single-cycle memory
    do_reset();
    rom[0] = 16'h1000;
    bus.run = 1'b1;
    step(5);
    chk("st_wr_cycles", 16'(n_wr), 16'd1);
    chk("st_we_pulses", 16'(n_we), 16'd0);
    chk("st_pc", bus.pc, 16'h0002);

    // Branches around pc=0x0010
    do_reset();
    rom[0] = 16'h5008;
    rom[7] = 16'h5008;
    rom[8] = 16'h303E;
    rom[9] = 16'h403E;
    bus.alu_zero = 1'b1;
    bus.run = 1'b1;
    step(4);
    chk("jmp10_pc", bus.pc, 16'h0010);
    step(2);
    chk("beq_pc_mid", bus.pc, 16'h0010);
    step(1);
    chk("beq_taken_pc", bus.pc, 16'h000E);
    chk("beq_cnt", bus.instr_count, 16'd2);
    step(3);
    chk("jmp_back_pc", bus.pc, 16'h0010);
    bus.alu_zero = 1'b0;
    step(3);
    chk("beq_nt_pc", bus.pc, 16'h0012);
    step(3);
    chk("bne_taken_pc", bus.pc, 16'h0010);
    chk("br_cnt", bus.instr_count, 16'd5);
    chk("br_strobes", 16'(n_we + n_req + n_rd + n_wr), 16'd0);

    // Max negative offset wraps below zero, then jumps in the top segment
    do_reset();
    rom[0] = 16'h3020;
    rom[1] = 16'h5000;
    bus.alu_zero = 1'b1;
    bus.run = 1'b1;
    step(4);
    chk("wrap_pc", bus.pc, 16'hFFC2);
    step(3);
    chk("jmp_e000_pc", bus.pc, 16'hE000);
    rom[0] = 16'h5123;
    step(3);
    chk("jmp_e246_pc", bus.pc, 16'hE246);
    chk("jmp_strobes", 16'(n_we + n_req + n_rd + n_wr), 16'd0);
    chk("jmp_cnt", bus.instr_count, 16'd3);

    // Illegal opcode halts and only reset recovers
    do_reset();
    rom[0] = 16'h2000;
    rom[1] = 16'h2000;
    rom[2] = 16'h7000;
    bus.run = 1'b1;
    step(9);
    chk("ill_pre_pc", bus.pc, 16'h0004);
    step(2);
    chk("ill_halted", {15'd0, bus.halted}, 16'd1);
    chk("ill_flag", {15'd0, bus.illegal}, 16'd1);
    chk("ill_pc", bus.pc, 16'h0004);
    chk("ill_cnt", bus.instr_count, 16'd2);
    clear_counts();
    bus.run = 1'b0;
    step(3);
    bus.run = 1'b1;
    step(3);
    chk("ill_hold_halted", {15'd0, bus.halted}, 16'd1);
    chk("ill_hold_pc", bus.pc, 16'h0004);
    chk("ill_hold_strobes", 16'(n_we + n_req + n_rd + n_wr), 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ill_rst_pc", bus.pc, 16'h0000);
    chk("ill_rst_flags", {14'd0, bus.halted, bus.illegal}, 16'h0);

    // Async reset in the middle of a stalled store
    do_reset();
    rom[0] = 16'h1000;
    bus.mem_ready = 1'b0;
    bus.run = 1'b1;
    step(4);
    chk("st_stall_strobes", {14'd0, bus.mem_req, bus.mem_write_enable}, 16'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("st_async_strobes", {14'd0, bus.mem_req, bus.mem_write_enable}, 16'h0);
    chk("st_async_pc", bus.pc, 16'h0000);

    // run dropped during EXEC still completes the ALU op
    do_reset();
    rom[0] = 16'h2000;
    rom[1] = 16'h2FFF;
    bus.run = 1'b1;
    step(3);
    bus.run = 1'b0;
    step(1);
    chk("drop_wb_we", {15'd0, bus.reg_write_enable}, 16'd1);
    step(4);
    chk("drop_pc", bus.pc, 16'h0002);
    chk("drop_cnt", bus.instr_count, 16'd1);
    chk("drop_ir_idle", bus.ir, 16'h2000);
    chk("drop_we_total", 16'(n_we), 16'd1);

    chk("onehot_strobes", 16'(n_multi), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spu_control_fsm.md
Name: spu_control_fsm

Overview:
Multi-cycle sequencer for the 16-bit SPU datapath: owns the PC, fetches from the instruction ROM, and steps each instruction through fetch, decode, execute, memory and writeback. It drives register-file write enable and data-memory read/write strobes, handshakes with data memory through mem_req/mem_ready, resolves branches and jumps, and halts on HALT or illegal opcodes. It sits between instruction_cache, registers and data_memory, replacing ad-hoc single-cycle control.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, byte increment per sequential instruction; ROM indexes by pc[4:1]

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
run  input  1  level; 1 = execute, 0 = stop at the next instruction boundary
instruction  input  16  ROM word for the current pc (combinational from ROM)
alu_zero  input  1  datapath zero flag, sampled in EXEC
mem_ready  input  1  data memory has completed the access; tie to 1 for the single-cycle RAM
pc  output  16  program counter, drives ROM counter
ir  output  16  latched instruction; the datapath decodes register and ALU fields from it
reg_write_enable  output  1  register-file write strobe
mem_req  output  1  data-memory access request
mem_read  output  1  load strobe
mem_write_enable  output  1  store strobe
halted  output  1  sticky; block is in HALT
illegal  output  1  sticky; halt was caused by an undefined opcode
instr_count  output  16  retired-instruction counter

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, instr_count=0, every strobe=0, halted=0, illegal=0. Outputs clear immediately, including mid-access.
- Opcode is ir[15:12]: 0 LD, 1 ST, 2 ALU, 3 BEQ, 4 BNE, 5 JMP, F HALT. All other values are illegal.
- Strobes are Moore outputs decoded from the registered state and ir. pc, ir and instr_count are registers.
- IDLE: run=1 -> FETCH.
- FETCH: ir <= instruction -> DECODE.
- DECODE: HALT -> HALT. Illegal -> HALT with illegal<=1. Otherwise -> EXEC.
- EXEC:
  - ALU -> WB.
  - LD or ST -> MEM.
  - BEQ/BNE: taken if alu_zero==1 (BEQ) or alu_zero==0 (BNE).
  - Taken target: pc+2+(sext(ir[5:0])<<1). Not taken: pc+2. Then go to the boundary.
  - JMP: pc <= {pc[15:13], ir[11:0], 1'b0}; go to the boundary.
- MEM:
  - mem_req=1, plus mem_read=1 (LD) or mem_write_enable=1 (ST).
  - Strobes hold every cycle until mem_ready=1.
  - On the mem_ready cycle: LD -> WB; ST -> pc+=2, go to the boundary.
- WB: reg_write_enable=1 for exactly one cycle, pc+=2, go to the boundary.
- Boundary (leaving EXEC branch/JMP, MEM store or WB):
  - instr_count += 1, wrapping 0xFFFF->0x0000.
  - Next state is FETCH if run=1, else IDLE.
  - A drop of run mid-instruction never aborts that instruction.
- HALT: halted=1, no strobes, pc frozen at the HALT/illegal instruction address, not counted as retired. Only rst_n exits HALT; run is ignored.
- PC arithmetic is modulo 2^16 (0xFFFE+2 = 0x0000). Branch offset range is -64..+62 bytes.
- Latency with mem_ready=1:
  - ALU 4 cycles (F,D,E,WB).
  - LD 5 cycles.
  - ST 4 cycles.
  - Branch and JMP 3 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- At most one of reg_write_enable, mem_read, mem_write_enable is high in any cycle.

Decomposition:
- spu_pkg holds:
  - opcode localparams (OP_LD..OP_HALT);
  - state typedef enum {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT};
  - field-position constants (OPC_MSB/LSB, BR_OFS_W=6, JMP_W=12).
- One sub-module, spu_next_pc: combinational next-PC selection (sequential, branch target, jump target) from pc, ir, alu_zero and state.

Test Plan:
1. Reset, run=1, ROM[0]=ALU (0x2xxx) -> reg_write_enable high only in cycle 4 after run; pc=0x0002; instr_count=1.
2. ROM[0]=LD, mem_ready held 0 for 3 MEM cycles -> mem_req and mem_read high 4 cycles; WB follows; reg_write_enable pulses once; pc=0x0002.
3. BEQ at pc=0x0010 with ir[5:0]=6'b111110:
   - alu_zero=1 -> pc=0x000E.
   - repeat with alu_zero=0 -> pc=0x0012.
   - 3 cycles each.
4. JMP at pc=0xE000 with ir[11:0]=0x123 -> pc=0xE246; no strobes asserted.
5. Opcode 0x7 at pc=0x0004 -> halted=1, illegal=1, pc=0x0004, instr_count unchanged; toggling run has no effect; rst_n pulse -> IDLE, pc=0x0000, flags clear.
6. ST in MEM with mem_ready=0, rst_n asserted mid-cycle -> mem_write_enable and mem_req drop without waiting for clk; pc=RESET_PC. Separately, run dropped during EXEC of an ALU op -> WB completes, then IDLE; pc=0x0002.
